// File: rtl/tmds_rx_if.sv
// ---------------------------------------------------------------------------
// tmds_rx_if: serial input and decoded output bundle for one TMDS channel.
// master = the decoder, slave = the downstream video sink / stream source.
// Optional feature macro: TMDS_RX_LOCK_STATS_EN (adds lock_loss_cnt).
// ---------------------------------------------------------------------------
interface tmds_rx_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       sym_valid;
  logic       locked;
`ifdef TMDS_RX_LOCK_STATS_EN
  logic [15:0] lock_loss_cnt;

  modport master (
    input  serial_in,
    output data_out, ctrl_out, de_out, sym_valid, locked, lock_loss_cnt
  );
  modport slave (
    output serial_in,
    input  data_out, ctrl_out, de_out, sym_valid, locked, lock_loss_cnt
  );
`else
  modport master (
    input  serial_in,
    output data_out, ctrl_out, de_out, sym_valid, locked
  );
  modport slave (
    output serial_in,
    input  data_out, ctrl_out, de_out, sym_valid, locked
  );
`endif
endinterface

// File: rtl/tmds_rx_decoder.sv
// ---------------------------------------------------------------------------
// tmds_rx_decoder: one TMDS channel, serial in (LSB first), finds symbol
// boundaries by locking onto control tokens, then undoes DC balancing and the
// XOR/XNOR transition-minimisation stage.
// Optional feature macro: TMDS_RX_LOCK_STATS_EN (saturating lock-loss counter).
// ---------------------------------------------------------------------------
module tmds_rx_decoder #(
  parameter int LOCK_COUNT    = 4,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input logic       clk,
  input logic       n_rst,
  tmds_rx_if.master rx
);

  localparam int TW  = $clog2(LOCK_COUNT + 1);
  localparam int TMW = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [TW-1:0]  LOCK_CNT_W = TW'(LOCK_COUNT);
  localparam logic [TMW-1:0] TMO_CNT_W  = TMW'(TOKEN_TIMEOUT);

  typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [9:0]      sr_q, sr_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   tok_cnt_q, tok_cnt_d;
  logic [TMW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            de_q, de_d;
  logic            valid_q, valid_d;
  logic            locked_q, locked_d;

  logic            boundary;
  logic            is_tok;
  logic [1:0]      tok_val;
  logic [7:0]      qi;
  logic [7:0]      dec;

  // Shift the new bit in at the top; the match looks at the updated window.
  assign sr_d     = {rx.serial_in, sr_q[9:1]};
  assign boundary = (bit_cnt_q == 4'd9);

  // Control-token recognition and data decode on the updated window.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (sr_d)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
    // Undo DC-balance inversion, then the XOR (q[8]=1) or XNOR (q[8]=0) chain.
    qi     = sr_d[9] ? ~sr_d[7:0] : sr_d[7:0];
    dec    = 8'h00;
    dec[0] = qi[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sr_d[8] ? (qi[i] ^ qi[i-1]) : ~(qi[i] ^ qi[i-1]);
    end
  end

  // Framing FSM next state, token/timeout counters and decoded outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
    tok_cnt_d = tok_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    de_d      = de_q;
    valid_d   = 1'b0;
    case (state_q)
      S_SEARCH: begin
        if (is_tok) begin
          // The token just completed, so the next bit is q[0] of a new symbol.
          bit_cnt_d = 4'd0;
          tok_cnt_d = TW'(1);
          tmo_cnt_d = '0;
          state_d   = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (boundary) begin
          if (is_tok) begin
            tok_cnt_d = tok_cnt_q + TW'(1);
            if (tok_cnt_d == LOCK_CNT_W) begin
              state_d   = S_LOCKED;
              tmo_cnt_d = '0;
            end
          end else begin
            state_d   = S_SEARCH;
            tok_cnt_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (boundary) begin
          if (is_tok) begin
            valid_d   = 1'b1;
            de_d      = 1'b0;
            ctrl_d    = tok_val;
            data_d    = 8'h00;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMW'(1);
            if (tmo_cnt_d == TMO_CNT_W) begin
              // Too long without a token: framing is suspect, drop this symbol.
              state_d   = S_SEARCH;
              tok_cnt_d = '0;
              tmo_cnt_d = '0;
            end else begin
              valid_d = 1'b1;
              de_d    = 1'b1;
              data_d  = dec;
            end
          end
        end
      end
      default: state_d = S_SEARCH;
    endcase
    locked_d = (state_d == S_LOCKED);
  end

`ifdef TMDS_RX_LOCK_STATS_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;

  // Count LOCKED->SEARCH transitions, saturating at all-ones.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (state_q == S_LOCKED && state_d == S_SEARCH && loss_cnt_q != 16'hFFFF) begin
      loss_cnt_d = loss_cnt_q + 16'd1;
    end
  end

  // Lock-loss counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!n_rst) loss_cnt_q <= '0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign rx.lock_loss_cnt = loss_cnt_q;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; n_rst is only looked at on the rising clk edge.
    if (!n_rst) begin
      state_q   <= S_SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      tok_cnt_q <= '0;
      tmo_cnt_q <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      tok_cnt_q <= tok_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      de_q      <= de_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
    end
  end

  assign rx.data_out  = data_q;
  assign rx.ctrl_out  = ctrl_q;
  assign rx.de_out    = de_q;
  assign rx.sym_valid = valid_q;
  assign rx.locked    = locked_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_rx_decoder: scoreboard bench for tmds_rx_decoder. Symbols are built
// by a reference TMDS encoder (data) or taken from the token table; a
// symbol-level model predicts strobes and lock state; a monitor pops and
// compares on every sym_valid.
// Optional feature macro: TMDS_RX_LOCK_STATS_EN (lock_loss_cnt checked too).
// ---------------------------------------------------------------------------
module tb_tmds_rx_decoder;

  localparam int LOCK_COUNT    = 4;
  localparam int TOKEN_TIMEOUT = 8;
  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
  } exp_t;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q [$];

  // Symbol-level model state
  bit         m_locked;
  int         m_streak;
  int         m_run;
  logic [1:0] m_ctrl;
  int         m_loss;

  tmds_rx_if rx_if ();

  tmds_rx_decoder #(.LOCK_COUNT(LOCK_COUNT), .TOKEN_TIMEOUT(TOKEN_TIMEOUT)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tok_index(input logic [9:0] q);
    for (int i = 0; i < 4; i++) if (q == TOK[i]) return i;
    return -1;
  endfunction

  // Transmit-side stage one plus optional DC-balance inversion.
  function automatic logic [9:0] tmds_encode(input logic [7:0] d, input bit use_xor,
                                             input bit invert);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    return {invert, use_xor, invert ? ~qm : qm};
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_streak = 0;
    m_run    = 0;
    m_ctrl   = 2'b00;
    m_loss   = 0;
  endtask

  // Called right after the boundary edge of a complete symbol.
  task automatic model_symbol(input logic [9:0] q, input logic [7:0] byte_exp);
    int   t;
    exp_t e;
    t = tok_index(q);
    if (!m_locked) begin
      if (t >= 0) begin
        m_streak++;
        if (m_streak == LOCK_COUNT) begin
          m_locked = 1'b1;
          m_run    = 0;
        end
      end else begin
        m_streak = 0;
      end
    end else if (t >= 0) begin
      m_run  = 0;
      m_ctrl = t[1:0];
      e = '{cyc: cyc, data: 8'h00, ctrl: m_ctrl, de: 1'b0};
      exp_q.push_back(e);
    end else begin
      m_run++;
      if (m_run == TOKEN_TIMEOUT) begin
        m_locked = 1'b0;
        m_streak = 0;
        m_loss++;
      end else begin
        e = '{cyc: cyc, data: byte_exp, ctrl: m_ctrl, de: 1'b1};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_bit(input logic b);
    rx_if.serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [9:0] q, input logic [7:0] byte_exp);
    for (int i = 0; i < 10; i++) send_bit(q[i]);
    model_symbol(q, byte_exp);
    @(negedge clk);
    check("locked", int'(rx_if.locked), int'(m_locked));
  endtask

  task automatic send_rand_data();
    logic [7:0] d;
    logic [9:0] q;
    do begin
      d = 8'($urandom);
      q = tmds_encode(d, 1'($urandom), 1'($urandom));
    end while (tok_index(q) >= 0);
    send_sym(q, d);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_out"},  int'(rx_if.data_out),  0);
    check({tag, "_ctrl_out"},  int'(rx_if.ctrl_out),  0);
    check({tag, "_de_out"},    int'(rx_if.de_out),    0);
    check({tag, "_sym_valid"}, int'(rx_if.sym_valid), 0);
    check({tag, "_locked"},    int'(rx_if.locked),    0);
`ifdef TMDS_RX_LOCK_STATS_EN
    check({tag, "_lock_loss_cnt"}, int'(rx_if.lock_loss_cnt), 0);
`endif
  endtask

  task automatic do_reset(input int cycles);
    n_rst = 1'b0;
    repeat (cycles) begin
      rx_if.serial_in = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    check_outputs_zero("reset");
    n_rst = 1'b1;
    model_reset();
  endtask

  // Straight after reset the window is all zeros, so a short random
  // preamble followed by tokens cannot produce a misaligned match.
  task automatic acquire_lock();
    repeat (3) send_bit(1'($urandom));
    repeat (LOCK_COUNT) send_sym(TOK[0], 8'h00);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      e = exp_q.pop_front();
      check("missed_sym_valid", int'(rx_if.sym_valid), 1);
    end
    if (rx_if.sym_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sym_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sym_cycle", cyc, e.cyc);
        check("de_out",    int'(rx_if.de_out),   int'(e.de));
        check("ctrl_out",  int'(rx_if.ctrl_out), int'(e.ctrl));
        check("data_out",  int'(rx_if.data_out), int'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] q;
    rx_if.serial_in = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset, then random bits in SEARCH: no strobe and no lock allowed
    do_reset(3);
    repeat (20) send_bit(1'($urandom));
    @(negedge clk);
    check("search_locked", int'(rx_if.locked), 0);

    // Lock acquisition and decode
    do_reset(1);
    acquire_lock();
    send_sym(TOK[0], 8'h00);
    send_sym(10'b0100000000, 8'h00);
    send_sym(10'b1010000110, 8'h75);
    for (int n = 0; n < 60; n++) begin
      if (m_run >= TOKEN_TIMEOUT - 2 || $urandom_range(3) == 0)
        send_sym(TOK[$urandom_range(3)], 8'h00);
      else
        send_rand_data();
    end
`ifdef TMDS_RX_LOCK_STATS_EN
    check("lock_loss_cnt_locked", int'(rx_if.lock_loss_cnt), m_loss);
`endif

    // Timeout: token, then TOKEN_TIMEOUT data symbols with no token
    send_sym(TOK[2], 8'h00);
    repeat (TOKEN_TIMEOUT) send_rand_data();
`ifdef TMDS_RX_LOCK_STATS_EN
    check("lock_loss_cnt_timeout", int'(rx_if.lock_loss_cnt), 1);
`endif

    // Verify failure: two tokens, then a data symbol
    do_reset(2);
    repeat (3) send_bit(1'($urandom));
    send_sym(TOK[0], 8'h00);
    send_sym(TOK[0], 8'h00);
    send_sym(10'b0100000000, 8'h00);
    repeat (3) @(negedge clk);
    check("verify_fail_locked", int'(rx_if.locked), 0);

    // Reset mid-lock at bit 5 of a symbol, then fresh relock
    do_reset(1);
    acquire_lock();
    send_rand_data();
    send_rand_data();
    q = 10'b0100000000;
    for (int i = 0; i < 5; i++) send_bit(q[i]);
    n_rst = 1'b0;
    send_bit(q[5]);
    n_rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_outputs_zero("midlock_reset");
    for (int i = 6; i < 10; i++) send_bit(q[i]);
    repeat (LOCK_COUNT) send_sym(TOK[0], 8'h00);
    send_sym(TOK[3], 8'h00);
    send_rand_data();

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_rx_decoder.md
Name: tmds_rx_decoder

Overview:
- Receive-side counterpart of the TMDS transmit encoder, which performs transition-minimisation stage one followed by DC balancing.
- Accepts one TMDS channel as a serial bit stream, one bit per clk, LSB of each 10-bit symbol first.
- Finds symbol boundaries by locking onto control tokens, then reverses DC balancing and the XOR/XNOR stage.
- Emits 8-bit pixel data or 2-bit control values with a per-symbol valid strobe, for the downstream video sink.

Parameters:
- LOCK_COUNT, 4: consecutive boundary-aligned control tokens required to declare lock. The first detection counts as 1.
- TOKEN_TIMEOUT, 4096: symbols allowed without any control token while LOCKED before lock is dropped.

Ports:
- clk  input  1  system clock, one serial bit per cycle
- n_rst  input  1  synchronous active-low reset
- serial_in  input  1  TMDS serial bit
- data_out  output  8  decoded pixel byte
- ctrl_out  output  2  decoded control value {c1,c0}
- de_out  output  1  1 = data symbol, 0 = control symbol
- sym_valid  output  1  one-cycle strobe; data_out, ctrl_out and de_out are valid while it is high
- locked  output  1  high while the FSM is in LOCKED

Behaviour:
- Reset (n_rst low at a clk edge) clears everything: shift register, bit counter 0..9, token counter, timeout counter, FSM = SEARCH, and every output = 0.
- Reset applies identically mid-symbol or mid-lock.
- Shift register sr[9:0]: each cycle sr <= {serial_in, sr[9:1]}. After 10 bits, sr[0] = q[0] and sr[9] = q[9].
- Control tokens, as q[9:0]:
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
- Token match is evaluated on the updated sr value, i.e. including the bit shifted in this cycle.
- FSM SEARCH:
  - Compare sr to all four tokens every cycle.
  - On a match: bit counter <= 0 (next bit is q[0] of the next symbol), token counter <= 1, go to VERIFY.
  - If LOCK_COUNT = 1, go directly to LOCKED instead.
- Boundary: the cycle in which bit counter = 9 and the tenth bit is shifted in. The counter wraps to 0.
- FSM VERIFY, evaluated at each boundary:
  - Token match: increment token counter. When it reaches LOCK_COUNT, go to LOCKED.
  - Any non-token symbol: go to SEARCH and clear the token counter.
- FSM LOCKED, at each boundary, decode the symbol and register the outputs:
  - sym_valid is high the cycle after the boundary edge (latency: 1 clk after the tenth bit is sampled), low otherwise.
  - Token symbol: de_out = 0, ctrl_out = token value, data_out = 0x00, timeout counter cleared.
  - Data symbol: de_out = 1, ctrl_out holds its last value.
  - Data decode, step 1: qi = q[9] ? ~q[7:0] : q[7:0].
  - Data decode, step 2: d[0] = qi[0]; for i = 1..7, d[i] = q[8] ? qi[i]^qi[i-1] : ~(qi[i]^qi[i-1]).
  - Each data symbol increments the timeout counter. When it reaches TOKEN_TIMEOUT, go to SEARCH, locked falls next cycle, and no sym_valid is issued for that symbol.
- locked is registered: it is high the cycle after the FSM enters LOCKED and low the cycle after it leaves.
- sym_valid is never high outside LOCKED.
- Data symbols that alias a token pattern are treated as tokens. This is protocol-legal because the encoder never produces token patterns for data.

Optional Feature:
- Macro: TMDS_RX_LOCK_STATS_EN.
- Defined:
  - Adds output lock_loss_cnt [15:0].
  - Increments on every LOCKED->SEARCH transition.
  - Saturates at 0xFFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold n_rst = 0 for 3 clks with random serial_in -> all outputs 0, locked = 0. Release n_rst -> no sym_valid while SEARCH.
- Lock acquisition: send 3 random bits, then token 1101010100 x4 -> locked = 1 one cycle after the fourth token's boundary. The next token yields sym_valid with de_out = 0, ctrl_out = 00.
- Data decode: locked, send 0100000000 -> data_out = 0x00. Send 1010000110 -> data_out = 0x75. Both with de_out = 1 and sym_valid one clk after the tenth bit.
- Verify failure: token x2, then data 0100000000 -> back to SEARCH, locked stays 0, no sym_valid.
- Timeout: locked with TOKEN_TIMEOUT = 8, send 8 data symbols with no token -> locked falls after the eighth boundary and only 7 sym_valid strobes occur. With TMDS_RX_LOCK_STATS_EN defined, lock_loss_cnt = 1.
- Reset mid-lock: assert n_rst for 1 clk during symbol bit 5 while locked -> locked = 0 and all outputs 0 next cycle. Relock requires 4 fresh tokens.
